// File: rtl/dacspi_slave.sv
// ============================================================================
// Module   : dacspi_slave
// Brief    : SPI slave for a four-channel 12-bit DAC front end. Decodes 32-bit
//            frames into input/DAC register writes. Optional MISO echo of the
//            previous frame is enabled by defining DACSPI_SLAVE_ECHO_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dacspi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK50MHZ,
    input  logic        RST,
    input  logic        SPI_SCK,
    input  logic        DAC_CS,
    input  logic        DAC_CLR,
    input  logic        SPI_MOSI,
    output logic        DAC_OUT,
    output logic [11:0] dac_a,
    output logic [11:0] dac_b,
    output logic [11:0] dac_c,
    output logic [11:0] dac_d,
    output logic        frame_valid,
    output logic        frame_error
);

    localparam int PIN_MOSI = 0;
    localparam int PIN_CLR  = 1;
    localparam int PIN_CS   = 2;
    localparam int PIN_SCK  = 3;
    localparam logic [5:0] FULL_FRAME = 6'd32;
    localparam logic [5:0] CNT_SAT    = 6'd33;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]             pins;
    logic [SYNC_STAGES-1:0] sync_chain [4];
    logic                   sck_s, cs_s, clr_s, mosi_s;
    logic                   sck_d, cs_d;
    logic                   sck_rise, cs_fall, cs_rise;

    logic [31:0] sr;
    logic [5:0]  cnt;
    logic [11:0] in_reg  [4];
    logic [11:0] dac_reg [4];

    logic        frame_ok;
    logic        frame_bad;
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [11:0] data;
    logic [3:0]  sel;

    assign pins = {SPI_SCK, DAC_CS, DAC_CLR, SPI_MOSI};

    // All synchronizers reset to 0 so a CS held low through reset never looks like a falling edge.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) sync_chain[i] <= '0;
            sck_d <= 1'b0;
            cs_d  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++)
                sync_chain[i] <= {sync_chain[i][SYNC_STAGES-2:0], pins[i]};
            sck_d <= sck_s;
            cs_d  <= cs_s;
        end
    end

    assign sck_s    = sync_chain[PIN_SCK][SYNC_STAGES-1];
    assign cs_s     = sync_chain[PIN_CS][SYNC_STAGES-1];
    assign clr_s    = sync_chain[PIN_CLR][SYNC_STAGES-1];
    assign mosi_s   = sync_chain[PIN_MOSI][SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign cs_fall  = ~cs_s & cs_d;
    assign cs_rise  = cs_s & ~cs_d;

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        frame_ok   = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE:  if (cs_fall) state_next = SHIFT;
            SHIFT: if (cs_rise) state_next = EXEC;
            EXEC: begin
                state_next = IDLE;
                if (cnt == FULL_FRAME) frame_ok  = 1'b1;
                else                   frame_bad = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            if (state == IDLE && cs_fall) cnt <= '0;
            if (state == SHIFT && sck_rise) begin
                sr <= (sr << 1) | {31'd0, mosi_s};
                if (cnt != CNT_SAT) cnt <= cnt + 6'd1;
            end
        end
    end

    assign cmd  = sr[23:20];
    assign addr = sr[19:16];
    assign data = sr[15:4];

    always_comb begin
        sel = 4'b0000;
        if (addr == 4'hF)       sel = 4'b1111;
        else if (addr < 4'd4)   sel = 4'b0001 << addr[1:0];
    end

    // Clear has priority; an unknown command or address still counts as a valid frame.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 4; i++) begin
                in_reg[i]  <= '0;
                dac_reg[i] <= '0;
            end
        end else if (!clr_s) begin
            for (int i = 0; i < 4; i++) begin
                in_reg[i]  <= '0;
                dac_reg[i] <= '0;
            end
        end else if (frame_ok && sel != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                case (cmd)
                    4'b0000: if (sel[i]) in_reg[i] <= data;
                    4'b0001: if (sel[i]) dac_reg[i] <= in_reg[i];
                    4'b0011: if (sel[i]) begin
                        in_reg[i]  <= data;
                        dac_reg[i] <= data;
                    end
                    4'b0010: begin
                        if (sel[i]) in_reg[i] <= data;
                        dac_reg[i] <= sel[i] ? data : in_reg[i];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_valid <= frame_ok;
            frame_error <= frame_bad;
        end
    end

    assign dac_a = dac_reg[0];
    assign dac_b = dac_reg[1];
    assign dac_c = dac_reg[2];
    assign dac_d = dac_reg[3];

`ifdef DACSPI_SLAVE_ECHO_EN
    logic sck_fall;
    logic echo;

    assign sck_fall = ~sck_s & sck_d;

    // Before the first shift sr still holds the previous frame, so its MSB goes out first.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST)
            echo <= 1'b0;
        else if ((state == IDLE && cs_fall) || (state == SHIFT && sck_fall))
            echo <= sr[31];
    end

    assign DAC_OUT = echo;
`else
    assign DAC_OUT = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dacspi_slave.sv
// ============================================================================
// Module   : tb_dacspi_slave
// Brief    : Directed self-checking bench for dacspi_slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dacspi_slave;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 6;

    logic        CLK50MHZ = 1'b0;
    logic        RST      = 1'b1;
    logic        SPI_SCK  = 1'b0;
    logic        DAC_CS   = 1'b1;
    logic        DAC_CLR  = 1'b1;
    logic        SPI_MOSI = 1'b0;
    logic        DAC_OUT;
    logic [11:0] dac_a, dac_b, dac_c, dac_d;
    logic        frame_valid, frame_error;

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_error = 0;
    int exp_valid = 0;
    int exp_error = 0;
    logic [31:0] echo;
    logic [31:0] exp_echo;
    logic [31:0] prev_frame;

    dacspi_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK50MHZ   (CLK50MHZ),
        .RST        (RST),
        .SPI_SCK    (SPI_SCK),
        .DAC_CS     (DAC_CS),
        .DAC_CLR    (DAC_CLR),
        .SPI_MOSI   (SPI_MOSI),
        .DAC_OUT    (DAC_OUT),
        .dac_a      (dac_a),
        .dac_b      (dac_b),
        .dac_c      (dac_c),
        .dac_d      (dac_d),
        .frame_valid(frame_valid),
        .frame_error(frame_error)
    );

    always #10 CLK50MHZ = ~CLK50MHZ;

    // Pulses are sampled once per cycle, so a stretched pulse counts more than once.
    always @(negedge CLK50MHZ) begin
        if (frame_valid === 1'b1) n_valid++;
        if (frame_error === 1'b1) n_error++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sck_bit(input logic b, output logic e);
        SPI_MOSI = b;
        repeat (HALF) @(negedge CLK50MHZ);
        e = DAC_OUT;
        SPI_SCK = 1'b1;
        repeat (HALF) @(negedge CLK50MHZ);
        SPI_SCK = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] word, input int nbits, output logic [31:0] e);
        logic b;
        e = '0;
        DAC_CS = 1'b0;
        repeat (8) @(negedge CLK50MHZ);
        for (int i = 0; i < nbits; i++) begin
            sck_bit(word[31-i], b);
            e[31-i] = b;
        end
        repeat (HALF) @(negedge CLK50MHZ);
        DAC_CS = 1'b1;
        repeat (12) @(negedge CLK50MHZ);
    endtask

    function automatic logic [31:0] echo_of(input logic [31:0] prev);
`ifdef DACSPI_SLAVE_ECHO_EN
        return prev;
`else
        return 32'd0 & prev;
`endif
    endfunction

    task automatic check_pulses(input string tag);
        check({tag, "_valid_cnt"}, n_valid, exp_valid);
        check({tag, "_error_cnt"}, n_error, exp_error);
    endtask

    initial begin
        logic b;
        repeat (5) @(negedge CLK50MHZ);
        check("rst_dac_a", {20'd0, dac_a}, 32'd0);
        check("rst_dac_d", {20'd0, dac_d}, 32'd0);
        check("rst_out",   {31'd0, DAC_OUT}, 32'd0);
        check("rst_pulse", {30'd0, frame_valid, frame_error}, 32'd0);
        RST = 1'b0;
        repeat (10) @(negedge CLK50MHZ);
        check_pulses("post_rst");

        // cmd 3 addr 0 data ABC
        send_frame(32'h0030ABC0, 32, echo);
        exp_valid++;
        check_pulses("f1");
        check("f1_dac_a", {20'd0, dac_a}, 32'h0ABC);
        check("f1_dac_bcd", {dac_b, dac_c, dac_d} == 36'd0 ? 32'd1 : 32'd0, 32'd1);
        check("f1_echo", echo, 32'd0);
        prev_frame = 32'h0030ABC0;

        // cmd 0 addr 1 data 123: input only
        send_frame(32'h00011230, 32, echo);
        exp_valid++;
        check_pulses("f2");
        check("f2_dac_b", {20'd0, dac_b}, 32'd0);
        exp_echo = echo_of(prev_frame);
        check("f2_echo", echo, exp_echo);
        prev_frame = 32'h00011230;

        // cmd 1 addr 1: copy input B to DAC B
        send_frame(32'h00110000, 32, echo);
        exp_valid++;
        check("f3_dac_b", {20'd0, dac_b}, 32'h123);
        exp_echo = echo_of(prev_frame);
        check("f3_echo", echo, exp_echo);

        send_frame(32'h00300ABC, 32, echo);
        exp_valid++;
        check("f4_dac_a", {20'd0, dac_a}, 32'h0AB);
        send_frame(32'h00311230, 32, echo);
        exp_valid++;
        exp_echo = echo_of(32'h00300ABC);
        check("f5_echo", echo, exp_echo);
        check("f5_dac_b", {20'd0, dac_b}, 32'h123);

        // cmd 2 addr 2 data 456: write input C, copy all inputs
        send_frame(32'h00224560, 32, echo);
        exp_valid++;
        check("f6_dac_a", {20'd0, dac_a}, 32'h0AB);
        check("f6_dac_b", {20'd0, dac_b}, 32'h123);
        check("f6_dac_c", {20'd0, dac_c}, 32'h456);
        check("f6_dac_d", {20'd0, dac_d}, 32'h000);

        // Unknown address, then unknown command: valid pulse, no change
        send_frame(32'h00357770, 32, echo);
        exp_valid++;
        send_frame(32'h007F7770, 32, echo);
        exp_valid++;
        check_pulses("f8");
        check("f8_dac_a", {20'd0, dac_a}, 32'h0AB);
        check("f8_dac_d", {20'd0, dac_d}, 32'h000);

        send_frame(32'h003FFFF0, 32, echo);
        exp_valid++;
        check("f9_all", {8'd0, dac_a ^ 12'hFFF, dac_b ^ 12'hFFF} | {8'd0, dac_c ^ 12'hFFF, dac_d ^ 12'hFFF}, 32'd0);

        // 31-bit frame is rejected
        send_frame(32'h00320010, 31, echo);
        exp_error++;
        check_pulses("f10");
        check("f10_dac_c", {20'd0, dac_c}, 32'hFFF);

        DAC_CLR = 1'b0;
        repeat (SYNC_STAGES + 2) @(negedge CLK50MHZ);
        check("clr_all", {8'd0, dac_a | dac_b, dac_c | dac_d}, 32'd0);
        DAC_CLR = 1'b1;
        repeat (8) @(negedge CLK50MHZ);

        send_frame(32'h0030ABC0, 32, echo);
        exp_valid++;
        check("f11_dac_a", {20'd0, dac_a}, 32'hABC);

        // Reset at bit 16; CS stays low across reset release
        DAC_CS = 1'b0;
        repeat (8) @(negedge CLK50MHZ);
        for (int i = 0; i < 16; i++) sck_bit(1'b1, b);
        RST = 1'b1;
        #1;
        check("abort_dac_a", {20'd0, dac_a}, 32'd0);
        check("abort_out", {31'd0, DAC_OUT}, 32'd0);
        repeat (3) @(negedge CLK50MHZ);
        RST = 1'b0;
        repeat (6) @(negedge CLK50MHZ);
        for (int i = 0; i < 4; i++) sck_bit(1'b1, b);
        DAC_CS = 1'b1;
        repeat (12) @(negedge CLK50MHZ);
        check_pulses("abort");
        check("abort_regs", {8'd0, dac_a | dac_b, dac_c | dac_d}, 32'd0);

        send_frame(32'h0033DEF0, 32, echo);
        exp_valid++;
        check_pulses("f12");
        check("f12_dac_d", {20'd0, dac_d}, 32'hDEF);
        check("f12_echo", echo, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
